// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin MUX select arbiter: requester count, FSM states, select codes.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (idx)
      SEL_A:   oh = 4'b0001;
      SEL_B:   oh = 4'b0010;
      SEL_C:   oh = 4'b0100;
      SEL_D:   oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set req bit after last_idx, last_idx itself lowest.
// Zero latency; no flow control.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_idx,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Offset 4 wraps back onto last_idx, so the current owner is considered last.
  always_comb begin
    found = 1'b0;
    idx   = last_idx;
    cand  = last_idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_idx + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving 4:1 MUX selects S0/S1 with a registered one-hot grant; ARB_LOCK_EN adds lock.
// One cycle from req sample to grant; requesters hold req until served, owner keeps up to HOLD_MAX cycles.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic               S0,
  output logic               S1,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic       own_req;
  logic       others;
  logic       hold_top;
  logic       lock_own;
  logic       do_grant;

  rr_pick u_pick (
    .req      (req),
    .last_idx (last_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign own_req  = req[last_q];
  assign others   = |(req & ~idx2oh(last_q));
  assign hold_top = (hold_q == CNT_W'(HOLD_MAX - 1));

`ifdef ARB_LOCK_EN
  assign lock_own = lock;
`else
  assign lock_own = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) do_grant = 1'b1;
      end
      ST_GRANT: begin
        if (!own_req) begin
          // Owner's bit is clear, so any pick here is a different requester.
          if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (hold_top && others && !lock_own) begin
          do_grant = 1'b1;
        end else if (!hold_top) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    if (do_grant) begin
      state_d = ST_GRANT;
      gnt_d   = idx2oh(pick_idx);
      last_d  = pick_idx;
      sel_d   = pick_idx;
      hold_d  = '0;
    end
  end

  // sel_q is separate from last_q: selects reset to A while the search pointer resets to D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= SEL_D;
      sel_q   <= SEL_A;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt  = gnt_q;
  assign S0   = sel_q[1];
  assign S1   = sel_q[0];
  assign busy = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected grant/select pushed per step, popped after the edge.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;
  logic [3:0] gnt;
  logic       S0, S1, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    string      tag;
  } exp_t;

  exp_t sb[$];

  mux_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .S0    (S0),
    .S1    (S1),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] eg, input logic [1:0] es, input string tag);
    exp_t e;
    e.gnt = eg;
    e.sel = es;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_gnt"},  gnt, e.gnt);
      chk({e.tag, "_sel"},  {2'b00, S0, S1}, {2'b00, e.sel});
      chk({e.tag, "_busy"}, {3'b000, busy}, {3'b000, |e.gnt});
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                      input string tag);
    @(negedge clk);
    req = r;
    push(eg, es, tag);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 1'b0;

    // Reset held with all requests active
    repeat (3) @(posedge clk);
    #1;
    push(4'b0000, 2'b00, "reset");
    compare_front();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(4'b0001, 2'b00, "release_A");
    compare_front();

    // Fairness: A already has one cycle, then 8 each for B, C, D, then back to A
    for (int c = 1; c < 8; c++) step(4'b1111, 4'b0001, 2'b00, "fair_A");
    for (int k = 1; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        logic [3:0] oh;
        oh = 4'b0001 << k;
        step(4'b1111, oh, 2'(k), "fair_rot");
      end
    end
    step(4'b1111, 4'b0001, 2'b00, "fair_wrap_A");

    // Early release: A drops to B, then B drops with A and D pending -> D
    step(4'b0010, 4'b0010, 2'b01, "drop_to_B");
    step(4'b1001, 4'b1000, 2'b11, "early_rel_D");

    // Idle hold of the select, then restart at A
    step(4'b0000, 4'b0000, 2'b11, "idle_hold");
    step(4'b0000, 4'b0000, 2'b11, "idle_stay");
    step(4'b0001, 4'b0001, 2'b00, "idle_to_A");

    // Non-owner dropping has no effect
    step(4'b0011, 4'b0001, 2'b00, "keep_A");
    step(4'b0001, 4'b0001, 2'b00, "nonowner_drop");
    step(4'b0100, 4'b0100, 2'b10, "drop_to_C");

    // Asynchronous reset between edges while C owns
    #2;
    rst_n = 1'b0;
    req   = 4'b0100;
    #1;
    push(4'b0000, 2'b00, "async_rst");
    compare_front();
    chk("async_rst_hold", dut.hold_q, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(4'b0100, 2'b10, "restart_C");
    compare_front();

    // Single requester: no rotation, hold counter saturates
    for (int c = 1; c < 20; c++) step(4'b0100, 4'b0100, 2'b10, "single_C");
    chk("hold_sat", dut.hold_q, 4'd7);

`ifdef ARB_LOCK_EN
    lock = 1'b1;
    for (int c = 0; c < 30; c++) step(4'b1111, 4'b0100, 2'b10, "lock_C");
    lock = 1'b0;
`endif

    // Saturated owner with others pending rotates on the next edge
    step(4'b1111, 4'b1000, 2'b11, "sat_rot_D");

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
